// File: rtl/debounce_pkg.sv
// Shared types and constants for the two-channel input conditioner.
package debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int N_CANAIS                = 2;

  // Counter width for a given debounce length; never collapses below one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_sync_if.sv
// Raw inputs in, clean levels and pending-change flags out.
interface debounce_sync_if;
  import debounce_pkg::*;

  logic [N_CANAIS-1:0] raw;
  logic [N_CANAIS-1:0] limpo;
  logic [N_CANAIS-1:0] instavel;

  modport master (output raw, input limpo, input instavel);
  modport slave  (input raw, output limpo, output instavel);
endinterface

// File: rtl/debounce_channel.sv
// One channel: two-flop synchroniser feeding an IDLE/CHECK debounce FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic limpo,
  output logic instavel
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Any sample agreeing with limpo while in CHECK discards all progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      limpo    <= 1'b0;
      instavel <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (sync2 != limpo) begin
            state    <= CHECK;
            cnt      <= CNT_W'(1);
            instavel <= 1'b1;
          end else begin
            cnt      <= '0;
            instavel <= 1'b0;
          end
        end
        CHECK: begin
          if (sync2 == limpo) begin
            state    <= IDLE;
            cnt      <= '0;
            instavel <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            limpo    <= sync2;
            state    <= IDLE;
            cnt      <= '0;
            instavel <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          instavel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// Two independent debounce channels driving the edge detector's entrada.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  debounce_sync_if.slave bus
);

  logic [N_CANAIS-1:0] limpo;
  logic [N_CANAIS-1:0] instavel;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (bus.raw[i]),
      .limpo    (limpo[i]),
      .instavel (instavel[i])
    );
  end

  assign bus.limpo    = limpo;
  assign bus.instavel = instavel;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with DEBOUNCE_CYCLES = 4.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  debounce_sync_if dbif ();

  debounce_sync #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dbif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] exp_l, input logic [1:0] exp_i);
    total++;
    assert (dbif.limpo === exp_l) else begin
      bad++;
      $error("FAIL %s limpo got=%b want=%b", tag, dbif.limpo, exp_l);
    end
    total++;
    assert (dbif.instavel === exp_i) else begin
      bad++;
      $error("FAIL %s instavel got=%b want=%b", tag, dbif.instavel, exp_i);
    end
  endtask

  task automatic do_reset(input int n, input logic [1:0] r);
    dbif.raw = r;
    rst = 1'b1;
    for (int k = 0; k < n; k++) step();
    rst = 1'b0;
  endtask

  logic train [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic tr_inst [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    dbif.raw = 2'b11;

    // 1: reset with raw held high, then full latency from release
    rst = 1'b1;
    step(); chk("rst_c1", 2'b00, 2'b00);
    step(); chk("rst_c2", 2'b00, 2'b00);
    rst = 1'b0;
    step(); chk("rel_R1", 2'b00, 2'b00);
    step(); chk("rel_R2", 2'b00, 2'b00);
    step(); chk("rel_R3", 2'b00, 2'b11);
    step(); chk("rel_R4", 2'b00, 2'b11);
    step(); chk("rel_R5", 2'b00, 2'b11);
    step(); chk("rel_R6", 2'b11, 2'b00);

    // 2: clean press on channel 0
    do_reset(1, 2'b00);
    dbif.raw = 2'b01;
    step(); chk("press_E0", 2'b00, 2'b00);
    step(); chk("press_E1", 2'b00, 2'b00);
    step(); chk("press_E2", 2'b00, 2'b01);
    step(); chk("press_E3", 2'b00, 2'b01);
    step(); chk("press_E4", 2'b00, 2'b01);
    step(); chk("press_E5", 2'b01, 2'b00);

    // 3: three-cycle glitch on channel 1 is rejected
    dbif.raw = 2'b11;
    step(); chk("glitch_E0", 2'b01, 2'b00);
    step(); chk("glitch_E1", 2'b01, 2'b00);
    step(); chk("glitch_E2", 2'b01, 2'b10);
    dbif.raw = 2'b01;
    step(); chk("glitch_E3", 2'b01, 2'b10);
    step(); chk("glitch_E4", 2'b01, 2'b10);
    step(); chk("glitch_E5", 2'b01, 2'b00);
    step(); chk("glitch_E6", 2'b01, 2'b00);
    step(); chk("glitch_E7", 2'b01, 2'b00);

    // 4: bounce train on channel 0
    do_reset(1, 2'b00);
    for (int k = 0; k < 11; k++) begin
      dbif.raw = (k < 9) ? {1'b0, train[k]} : 2'b01;
      step();
      chk($sformatf("bounce_E%0d", k), (k == 10) ? 2'b01 : 2'b00, {1'b0, tr_inst[k]});
    end

    // 5: both channels flip in opposite directions on the same edge
    dbif.raw = 2'b10;
    step(); chk("opp_E0", 2'b01, 2'b00);
    step(); chk("opp_E1", 2'b01, 2'b00);
    step(); chk("opp_E2", 2'b01, 2'b11);
    step(); chk("opp_E3", 2'b01, 2'b11);
    step(); chk("opp_E4", 2'b01, 2'b11);
    step(); chk("opp_E5", 2'b10, 2'b00);

    // 6: reset at cnt=2 abandons the pending change
    do_reset(1, 2'b00);
    dbif.raw = 2'b01;
    step(); step(); step(); step();
    chk("midchk_cnt2", 2'b00, 2'b01);
    rst = 1'b1;
    step(); chk("midchk_rst", 2'b00, 2'b00);
    rst = 1'b0;
    step(); chk("midchk_R1", 2'b00, 2'b00);
    step(); chk("midchk_R2", 2'b00, 2'b00);
    step(); chk("midchk_R3", 2'b00, 2'b01);
    step(); chk("midchk_R4", 2'b00, 2'b01);
    step(); chk("midchk_R5", 2'b00, 2'b01);
    step(); chk("midchk_R6", 2'b01, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
